// File: rtl/conv_adrgen_v2.sv
// conv_adrgen_v2: tap-by-tap address generator for a multi-lane convolution engine.
// It walks the channel/filter/pixel loops and emits input, filter, bias and output addresses.
module conv_adrgen_v2 #(
  parameter int NP = 4,
  parameter int AW = 24,
  parameter int DW = 11,
  parameter int KW = 3
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic                   kick,
  input  logic                   abort,
  input  logic                   pwe,
  input  logic [7:0]             padr,
  input  logic [31:0]            pdata,
  output logic [NP-1:0][AW-1:0]  in_adr,
  output logic [NP-1:0]          valid,
  input  logic                   in_rdy,
  input  logic                   fil_rdy,
  input  logic                   bias_rdy,
  output logic [AW-1:0]          fil_adr,
  output logic [AW-1:0]          bias_adr,
  output logic [NP-1:0][AW-1:0]  out_adr,
  output logic [NP-1:0]          oen,
  input  logic                   out_rdy,
  output logic                   run,
  output logic                   aen,
  output logic                   acl,
  input  logic                   acvalid,
  output logic                   done
);
  localparam int SW = AW + 8;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACC, ST_FLUSH, ST_TERM} state_t;

  state_t state_reg, state_next;
  logic   setup_cnt_reg;
  logic   acl_reg, acl_next;
  logic   done_reg, done_next;

  logic [DW-1:0] in_h_reg, in_w_reg, in_c_reg;
  logic [DW-1:0] out_h_reg, out_w_reg, out_c_reg, p_h_reg;
  logic [KW-1:0] fil_h_reg, fil_w_reg;
  logic [KW-1:0] str_h_reg, dil_h_reg, pad_h_reg;
  logic [KW-1:0] str_w_reg, dil_w_reg, pad_w_reg;
  logic          depthmul_reg;
  logic [7:0]    n_chen_reg;

  logic [DW-1:0] ci_reg, oc_reg, a_reg;
  logic [KW-1:0] fx_reg, fy_reg;

  logic rdy, param_we, start_load, acc_fire, lane_step;
  logic ci_last, fx_last, fy_last, oc_last, a_last, tap_last;
  logic [DW-1:0] ch1_c, ch2_c, chan;
  logic [SW-1:0] tap_idx;
  logic [AW-1:0] fil_calc;
  logic [NP-1:0][AW-1:0] lane_in_adr, lane_out_adr;
  logic [NP-1:0] lane_valid, lane_en;
  logic unused_pdata;

  // Tolerates a zero loop bound by treating it as a single iteration.
  function automatic logic is_last(input logic [DW-1:0] v, input logic [DW-1:0] n);
    return ({1'b0, v} + (DW+1)'(1)) >= {1'b0, n};
  endfunction

  assign rdy          = in_rdy & fil_rdy & bias_rdy;
  assign run          = (state_reg != ST_IDLE);
  assign param_we     = pwe & ~run;
  assign start_load   = (state_reg == ST_IDLE) & kick & ~abort;
  assign acc_fire     = (state_reg == ST_ACC) & rdy & ~abort;
  assign lane_step    = acc_fire & tap_last & oc_last;
  assign acl          = acl_reg;
  assign done         = done_reg;
  assign unused_pdata = ^pdata;

  assign ch1_c    = depthmul_reg ? in_c_reg : out_c_reg;
  assign ch2_c    = depthmul_reg ? DW'(1) : in_c_reg;
  assign chan     = depthmul_reg ? oc_reg : ci_reg;
  assign ci_last  = is_last(ci_reg, ch2_c);
  assign fx_last  = is_last(DW'(fx_reg), DW'(fil_w_reg));
  assign fy_last  = is_last(DW'(fy_reg), DW'(fil_h_reg));
  assign oc_last  = is_last(oc_reg, ch1_c);
  assign a_last   = is_last(a_reg, p_h_reg);
  assign tap_last = ci_last & fx_last & fy_last;

  assign tap_idx  = SW'(fy_reg) * SW'(fil_w_reg) + SW'(fx_reg);
  assign fil_calc = depthmul_reg
                  ? AW'(tap_idx * SW'(out_c_reg) + SW'(oc_reg))
                  : AW'(SW'(oc_reg) * SW'(fil_h_reg) * SW'(fil_w_reg) * SW'(in_c_reg)
                        + tap_idx * SW'(in_c_reg) + SW'(ci_reg));

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      in_h_reg     <= '0;
      in_w_reg     <= '0;
      in_c_reg     <= '0;
      fil_h_reg    <= '0;
      fil_w_reg    <= '0;
      out_h_reg    <= '0;
      out_w_reg    <= '0;
      out_c_reg    <= '0;
      p_h_reg      <= '0;
      str_h_reg    <= '0;
      dil_h_reg    <= '0;
      pad_h_reg    <= '0;
      str_w_reg    <= '0;
      dil_w_reg    <= '0;
      pad_w_reg    <= '0;
      depthmul_reg <= 1'b0;
      n_chen_reg   <= '0;
    end else if (param_we) begin
      case (padr)
        8'd0:  in_h_reg  <= pdata[DW-1:0];
        8'd1:  in_w_reg  <= pdata[DW-1:0];
        8'd2:  in_c_reg  <= pdata[DW-1:0];
        8'd3:  fil_h_reg <= pdata[KW-1:0];
        8'd4:  fil_w_reg <= pdata[KW-1:0];
        8'd5:  out_h_reg <= pdata[DW-1:0];
        8'd6:  out_w_reg <= pdata[DW-1:0];
        8'd7:  out_c_reg <= pdata[DW-1:0];
        8'd8:  p_h_reg   <= pdata[DW-1:0];
        8'd9:  {str_h_reg, dil_h_reg, pad_h_reg} <= pdata[3*KW-1:0];
        8'd10: {str_w_reg, dil_w_reg, pad_w_reg} <= pdata[3*KW-1:0];
        8'd11: depthmul_reg <= pdata[0];
        8'd12: n_chen_reg   <= pdata[7:0];
        default: ;
      endcase
    end
  end

  // Per-lane start position, current pixel and address arithmetic.
  for (genvar gi = 0; gi < NP; gi++) begin : g_lane
    logic [DW-1:0] start_y_reg, start_x_reg, oy_reg, ox_reg;
    logic signed [SW-1:0] iy, ix;

    always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
        start_y_reg <= '0;
        start_x_reg <= '0;
      end else if (param_we && padr == 8'(16 + gi)) begin
        start_y_reg <= pdata[16 +: DW];
        start_x_reg <= pdata[DW-1:0];
      end
    end

    always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
        oy_reg <= '0;
        ox_reg <= '0;
      end else if (start_load) begin
        oy_reg <= start_y_reg;
        ox_reg <= start_x_reg;
      end else if (lane_step && lane_en[gi]) begin
        if (ox_reg == out_w_reg - DW'(1)) begin
          ox_reg <= '0;
          oy_reg <= oy_reg + DW'(1);
        end else begin
          ox_reg <= ox_reg + DW'(1);
        end
      end
    end

    always_comb begin
      iy = SW'(oy_reg) * SW'(str_h_reg) - SW'(pad_h_reg) + SW'(fy_reg) * SW'(dil_h_reg);
      ix = SW'(ox_reg) * SW'(str_w_reg) - SW'(pad_w_reg) + SW'(fx_reg) * SW'(dil_w_reg);
    end

    assign lane_en[gi]      = (8'(gi) < n_chen_reg) && (oy_reg < out_h_reg);
    assign lane_valid[gi]   = !iy[SW-1] && (iy < $signed(SW'(in_h_reg)))
                           && !ix[SW-1] && (ix < $signed(SW'(in_w_reg)));
    assign lane_in_adr[gi]  = AW'((iy * $signed(SW'(in_w_reg)) + ix) * $signed(SW'(in_c_reg))
                                 + $signed(SW'(chan)));
    assign lane_out_adr[gi] = AW'((SW'(oy_reg) * SW'(out_w_reg) + SW'(ox_reg)) * SW'(out_c_reg)
                                 + SW'(oc_reg));
  end

  // Loop nest: in_c innermost, then fil_x, fil_y, out_c, pixel index.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      ci_reg <= '0;
      fx_reg <= '0;
      fy_reg <= '0;
      oc_reg <= '0;
      a_reg  <= '0;
    end else if (start_load) begin
      ci_reg <= '0;
      fx_reg <= '0;
      fy_reg <= '0;
      oc_reg <= '0;
      a_reg  <= '0;
    end else if (acc_fire) begin
      if (!ci_last) begin
        ci_reg <= ci_reg + DW'(1);
      end else begin
        ci_reg <= '0;
        if (!fx_last) begin
          fx_reg <= fx_reg + KW'(1);
        end else begin
          fx_reg <= '0;
          if (!fy_last) begin
            fy_reg <= fy_reg + KW'(1);
          end else begin
            fy_reg <= '0;
            if (!oc_last) begin
              oc_reg <= oc_reg + DW'(1);
            end else begin
              oc_reg <= '0;
              a_reg  <= a_reg + DW'(1);
            end
          end
        end
      end
    end
  end

  // Address outputs trail the counters by one ready cycle and hold while stalled.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      in_adr   <= '0;
      valid    <= '0;
      fil_adr  <= '0;
      bias_adr <= '0;
      out_adr  <= '0;
      oen      <= '0;
      aen      <= 1'b0;
    end else if (abort) begin
      valid <= '0;
      oen   <= '0;
      aen   <= 1'b0;
    end else if (rdy) begin
      if (state_reg == ST_ACC) begin
        in_adr   <= lane_in_adr;
        valid    <= lane_valid;
        fil_adr  <= fil_calc;
        bias_adr <= AW'(oc_reg);
        out_adr  <= lane_out_adr;
        oen      <= lane_en;
        aen      <= 1'b1;
      end else begin
        aen <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_reg     <= ST_IDLE;
      setup_cnt_reg <= 1'b0;
      acl_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      setup_cnt_reg <= (state_reg == ST_SETUP) ? ~setup_cnt_reg : 1'b0;
      acl_reg       <= acl_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acl_next   = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE:  if (kick) state_next = ST_SETUP;
      ST_SETUP: if (setup_cnt_reg) state_next = ST_ACC;
      ST_ACC: begin
        if (rdy && tap_last) state_next = (oc_last && a_last) ? ST_TERM : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (acvalid && out_rdy) begin
          state_next = ST_ACC;
          acl_next   = 1'b1;
        end
      end
      ST_TERM: begin
        if (acvalid && out_rdy) begin
          state_next = ST_IDLE;
          acl_next   = 1'b1;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next == ST_SETUP) acl_next = 1'b1;
    if (abort) begin
      state_next = ST_IDLE;
      acl_next   = 1'b0;
      done_next  = 1'b0;
    end
  end

endmodule

// File: doc/conv_adrgen_v2.md
CONV_ADRGEN_V2 -- requirements
Module: conv_adrgen_v2

Interface
REQ-001 SHALL have parameter NP, default 4: number of parallel output-pixel lanes, legal range 1..16.
REQ-002 SHALL have parameter AW, default 24: byte-address width of in_adr, fil_adr, out_adr and bias_adr.
REQ-003 SHALL have parameter DW, default 11: width of the H, W and C dimension registers.
REQ-004 SHALL have parameter KW, default 3: width of filH, filW, stride, dilation and padding.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- xrst  in  1  asynchronous, active-high reset.
- kick  in  1  start one frame.
- abort  in  1  cancel the current frame.
- pwe  in  1  parameter write strobe.
- padr  in  8  parameter address.
- pdata  in  32  parameter write data.
- in_adr  out  NP x AW  input byte addresses.
- valid  out  NP  in_adr lies inside the input bounds.
- in_rdy / fil_rdy / bias_rdy  in  1  read-side ready signals.
- fil_adr  out  AW  filter address.
- bias_adr  out  AW  bias address.
- out_adr  out  NP x AW  output addresses.
- oen  out  NP  output enable per lane.
- out_rdy  in  1  write-side ready.
- run  out  1  frame active.
- aen  out  1  accumulate enable.
- acl  out  1  accumulator clear.
- acvalid  in  1  accumulator result valid.
- done  out  1  one-cycle end-of-frame pulse.

Function
REQ-006 Parameter map, written only when pwe=1 and run=0 (writes while run=1 SHALL be ignored):
- 0 inH, 1 inW, 2 inC, 3 filH, 4 filW.
- 5 outH, 6 outW, 7 outC.
- 8 pH: pixels per lane.
- 9 {strH,dilH,padH}, 10 {strW,dilW,padW}: KW bits each, MSB field first.
- 11 depthmul: bit 0.
- 12 n_chen.
- 16+i: lane i start position, y=pdata[26:16], x=pdata[10:0].
REQ-007 The signal rdy = in_rdy & fil_rdy & bias_rdy; whenever rdy=0, in_adr, valid, fil_adr and aen SHALL hold their previous values and every counter SHALL freeze.
REQ-008 The FSM SHALL have states Idle, Setup, Acc, Flush and Term.
- Idle->Setup on kick.
- Setup SHALL last exactly 2 cycles with acl=1, then go to Acc.
REQ-009 Acc SHALL iterate in_c (innermost, 0..ch2C-1), then fil_x, then fil_y, then out_c (0..ch1C-1), then pixel index a (0..pH-1).
- depthmul=0: ch1C=outC, ch2C=inC.
- depthmul=1: ch1C=inC, ch2C=1.
REQ-010 in_adr[i] SHALL equal (iy*inW+ix)*C3 + c.
- iy = oy_i*strH - padH + fil_y*dilH; ix = ox_i*strW - padW + fil_x*dilW.
- C3 = inC; c = out_c if depthmul=1, else in_c.
- The calculation SHALL use signed arithmetic of at least AW+4 bits.
REQ-011 valid[i] SHALL be 1 iff 0<=ix<inW and 0<=iy<inH; addresses SHALL appear one rdy-qualified cycle after the counter values.
REQ-012 fil_adr SHALL be computed as follows.
- depthmul=0: out_c*filH*filW*inC + (fil_y*filW+fil_x)*inC + in_c.
- depthmul=1: (fil_y*filW+fil_x)*outC + out_c.
- bias_adr SHALL equal out_c.
REQ-013 out_adr[i] SHALL equal (oy_i*outW+ox_i)*outC + out_c.
REQ-014 oen[i] SHALL be 1 iff i<n_chen and oy_i<outH.
REQ-015 aen SHALL be 1 in Acc, and SHALL be 0 from the first rdy cycle in Flush or Term.
REQ-016 After the last tap, the FSM SHALL enter Flush, or Term if the last (out_c,a) pair is done.
- In Flush, acvalid&out_rdy SHALL give acl=1 for one cycle and return to Acc.
- In Term, acvalid&out_rdy SHALL give acl=1 and done=1 for one cycle, run=0, then Idle.
REQ-017 Lane position update: when out_c wraps to 0, each lane with oen=1 SHALL advance ox.
- If ox=outW-1, ox SHALL become 0 and oy SHALL increment.
- Otherwise ox SHALL increment.
REQ-018 kick while run=1 SHALL be ignored.
REQ-019 abort SHALL force the next state to Idle from any state, clearing run, aen, acl and valid without asserting done.
REQ-020 If abort and kick are both 1 in the same cycle, abort SHALL win.

Reset
REQ-021 While xrst=1, all of the following SHALL be asynchronously forced and held:
- state=Idle.
- run, aen, acl, done, valid and oen = 0.
- all addresses and counters = 0.
REQ-022 Parameter registers SHALL reset to 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; no done pulse SHALL be issued.

Verification
REQ-024 Conv 4x4x2 input, 3x3 filter, stride 1, pad 1, outC=1, NP=1, rdy always 1 -> 9x2 taps per pixel; the first in_adr sequence is valid=0 for y=-1; 16 acl pulses; done after the 16th acvalid.
REQ-025 Depthwise inC=outC=3, dil=2, 5x5 input, pad 2 -> fil_adr steps by outC=3; ix steps by 2; 9 taps per channel.
REQ-026 rdy toggled 1,0,0,1 repeatedly -> in_adr and fil_adr are frozen during 0 cycles; the address sequence is identical to the rdy=1 run.
REQ-027 NP=4, n_chen=3, pH=2 -> oen[3]=0 throughout; lanes 0-2 wrap x at outW-1.
REQ-028 abort asserted mid-Acc -> run=0 on the next cycle, done=0; a subsequent kick produces the full, correct sequence.
REQ-029 pwe to address 1 while run=1 -> inW is unchanged after the frame.
